// File: rtl/dataframe_pkg.sv
// Shared constants and state encoding for the frame store drain path.
package dataframe_pkg;

  localparam int FRAME_W         = 448;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_FRAME = 14;

  localparam logic [15:0] HDR_MAGIC = 16'hDF5A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/dataframe_reader_if.sv
// Store-read and outgoing word-stream signals of the dataframe reader.
interface dataframe_reader_if;
  import dataframe_pkg::*;

  logic [FRAME_W-1:0] fifo_data;
  logic [6:0]         fifo_num_elem;
  logic               fifo_rd_en;
  logic [WORD_W-1:0]  m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;

  modport master (
    input  fifo_data, fifo_num_elem, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_data, fifo_num_elem, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );

endinterface

// File: rtl/dataframe_reader_serializer.sv
// Frame-to-word serializer; DATAFRAME_READER_HEADER_EN prefixes a {magic, count} word.
module dataframe_serializer
  import dataframe_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic [15:0]        hdr_cnt_i,
  input  logic               m_ready_i,
  output logic [WORD_W-1:0]  m_data_o,
  output logic               m_valid_o,
  output logic               m_last_o,
  output logic               done_o
);

`ifdef DATAFRAME_READER_HEADER_EN
  localparam int NWORDS = WORDS_PER_FRAME + 1;
`else
  localparam int NWORDS = WORDS_PER_FRAME;
`endif
  localparam int         SR_W     = NWORDS * WORD_W;
  localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

  logic [SR_W-1:0] sr_q, sr_d;
  logic [3:0]      idx_q, idx_d;
  logic            valid_q, valid_d;
  logic [SR_W-1:0] load_val;
  logic            xfer;

`ifdef DATAFRAME_READER_HEADER_EN
  // Header sits in the low word so it leaves first; data follows unchanged.
  assign load_val = {frame_i, HDR_MAGIC, hdr_cnt_i};
`else
  assign load_val = frame_i;
`endif

  assign xfer      = valid_q && m_ready_i;
  assign m_data_o  = sr_q[WORD_W-1:0];
  assign m_valid_o = valid_q;
  assign m_last_o  = valid_q && (idx_q == LAST_IDX);
  assign done_o    = xfer && (idx_q == LAST_IDX);

  always_comb begin
    sr_d    = sr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      sr_d    = load_val;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      // After the final shift the register is all zero, so m_data idles at 0.
      sr_d  = sr_q >> WORD_W;
      idx_d = idx_q + 4'd1;
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sr_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/dataframe_reader.sv
// Drains the pixel frame store one 448-bit frame at a time into a 32-bit stream.
// Optional header word per frame: define DATAFRAME_READER_HEADER_EN.
module dataframe_reader
  import dataframe_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rstb,
  dataframe_reader_if.master  bus,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam logic [0:0] IDLE          = 1'(ST_IDLE);
  localparam logic [0:0] SEND          = 1'(ST_SEND);
  localparam logic [3:0] SETTLE_INIT   = 4'(RD_LAT);
  localparam logic [3:0] SETTLE_RELOAD = 4'(RD_LAT + 2);

  logic [0:0]  state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic        fifo_rd_en_q, fifo_rd_en_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        capture;
  logic        done;

  // settle guards against sampling occupancy or data before the head move has propagated.
  assign capture = (state_q == IDLE) && (bus.fifo_num_elem != '0) && (settle_q == '0);

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    fifo_rd_en_d = capture;
    frame_cnt_d  = frame_cnt_q;
    if (settle_q != '0) begin
      settle_d = settle_q - 4'd1;
    end
    if (capture) begin
      state_d  = SEND;
      settle_d = SETTLE_RELOAD;
    end else if (done) begin
      state_d     = IDLE;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      settle_q     <= SETTLE_INIT;
      fifo_rd_en_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.fifo_rd_en = fifo_rd_en_q;
  assign busy           = (state_q == SEND);
  assign frame_cnt      = frame_cnt_q;

  dataframe_serializer u_ser (
    .clk       (clk),
    .rstb      (rstb),
    .load_i    (capture),
    .frame_i   (bus.fifo_data),
    .hdr_cnt_i (frame_cnt_q),
    .m_ready_i (bus.m_ready),
    .m_data_o  (bus.m_data),
    .m_valid_o (bus.m_valid),
    .m_last_o  (bus.m_last),
    .done_o    (done)
  );

endmodule

// File: tb/tb_dataframe_reader.sv
// Scoreboard bench for dataframe_reader with a latency-modelled frame store.
module tb_dataframe_reader;
  import dataframe_pkg::*;

  localparam int RD_LAT = 2;
`ifdef DATAFRAME_READER_HEADER_EN
  localparam int NW = WORDS_PER_FRAME + 1;
`else
  localparam int NW = WORDS_PER_FRAME;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        m_ready = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  dataframe_reader_if bus ();

  dataframe_reader #(.RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  // Store model: pushed is advanced by tests only, popped_q by the store only.
  logic [FRAME_W-1:0] mem [0:15];
  int                 pushed = 0;
  int                 popped_q = 0;
  logic [FRAME_W-1:0] d1, d2;

  always @(posedge clk) begin
    d1 <= mem[popped_q % 16];
    d2 <= d1;
    if (bus.fifo_rd_en) popped_q <= popped_q + 1;
  end

  assign bus.fifo_data     = d2;
  assign bus.fifo_num_elem = 7'(pushed - popped_q);
  assign bus.m_ready       = m_ready;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  int   pops = 0;
  int   xfers = 0;
  int   valid_cycles = 0;
  int   exp_fc = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   end_cyc = 0;
  int   widx = 0;
  logic [31:0] first_words[$];
  logic        prev_stall = 1'b0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Monitor: pushes expected words on each pop, pops and compares on each transfer.
  always @(negedge clk) begin
    exp_t e;
    logic [FRAME_W-1:0] fr;
    cyc++;
    if (!rstb) begin
      prev_stall = 1'b0;
      prev_rd    = 1'b0;
      widx       = 0;
    end else begin
      if (bus.fifo_rd_en) begin
        pops++;
        checks++;
        if (prev_rd) $display("FAIL rd_en_pulse: got 2-cycle strobe required 1-cycle");
        else passes++;
        start_cyc = cyc;
        fr = mem[popped_q % 16];
`ifdef DATAFRAME_READER_HEADER_EN
        e.data = {HDR_MAGIC, 16'(exp_fc)};
        e.last = 1'b0;
        sb.push_back(e);
`endif
        for (int k = 0; k < WORDS_PER_FRAME; k++) begin
          e.data = fr[k*32 +: 32];
          e.last = (k == WORDS_PER_FRAME - 1);
          sb.push_back(e);
        end
      end
      prev_rd = bus.fifo_rd_en;
      if (bus.m_valid) valid_cycles++;
      checks++;
      if (busy !== bus.m_valid) $display("FAIL busy: got %b required %b", busy, bus.m_valid);
      else passes++;
      if (prev_stall) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last)
          $display("FAIL stall_hold: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
        else passes++;
      end
      if (bus.m_valid && m_ready) begin
        xfers++;
        if (widx == 0) first_words.push_back(bus.m_data);
        widx++;
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL word: got %h last=%b required no transfer", bus.m_data, bus.m_last);
        end else begin
          e = sb.pop_front();
          if (bus.m_data !== e.data || bus.m_last !== e.last)
            $display("FAIL word: got %h last=%b required %h last=%b",
                     bus.m_data, bus.m_last, e.data, e.last);
          else passes++;
          if (e.last) begin
            exp_fc++;
            end_cyc = cyc;
            widx = 0;
          end
        end
      end
      prev_stall = bus.m_valid && !m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  task automatic add_frames(input int n, input logic [31:0] base, input bit rnd);
    for (int f = 0; f < n; f++) begin
      logic [FRAME_W-1:0] fr;
      for (int k = 0; k < WORDS_PER_FRAME; k++)
        fr[k*32 +: 32] = rnd ? $urandom : base + 32'(f * 256 + k);
      mem[(pushed + f) % 16] = fr;
    end
    repeat (RD_LAT + 1) @(posedge clk);
    #1 pushed = pushed + n;
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
        busy !== 1'b0 || bus.m_data !== 32'h0 || frame_cnt !== 16'h0)
      $display("FAIL reset: got rd=%b v=%b l=%b b=%b d=%h fc=%h required all 0",
               bus.fifo_rd_en, bus.m_valid, bus.m_last, busy, bus.m_data, frame_cnt);
    else passes++;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_empty;
    int p0 = pops;
    int v0 = valid_cycles;
    repeat (100) @(posedge clk);
    checks++;
    if (pops - p0 != 0) $display("FAIL empty_pop: got %0d pops required 0", pops - p0);
    else passes++;
    checks++;
    if (valid_cycles - v0 != 0) $display("FAIL empty_valid: got %0d cycles required 0", valid_cycles - v0);
    else passes++;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frame_cnt != 16'(target) && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (frame_cnt != 16'(target)) $display("FAIL %s_timeout: got frame_cnt %0d required %0d", tag, frame_cnt, target);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int p0 = pops;
    int x0 = xfers;
    int fc0 = exp_fc;
    m_ready = 1'b1;
    add_frames(1, 32'h1000, 1'b0);
    wait_frames(fc0 + 1, "single");
    checks++;
    if (pops - p0 != 1) $display("FAIL single_pops: got %0d required 1", pops - p0);
    else passes++;
    checks++;
    if (xfers - x0 != NW) $display("FAIL single_words: got %0d required %0d", xfers - x0, NW);
    else passes++;
    checks++;
    if (end_cyc - start_cyc != NW - 1) $display("FAIL single_span: got %0d required %0d", end_cyc - start_cyc, NW - 1);
    else passes++;
    checks++;
    if (frame_cnt !== 16'd1) $display("FAIL single_cnt: got %0d required 1", frame_cnt);
    else passes++;
  endtask

  task automatic test_backpressure;
    int p0 = pops;
    int x0 = xfers;
    int target = exp_fc + 1;
    int n = 0;
    add_frames(1, 32'h0, 1'b1);
    while (frame_cnt != 16'(target) && n < 2000) begin
      @(posedge clk);
      #1 m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    checks++;
    if (frame_cnt != 16'(target)) $display("FAIL bp_timeout: got frame_cnt %0d required %0d", frame_cnt, target);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pops - p0 != 1 || xfers - x0 != NW)
      $display("FAIL bp_count: got pops=%0d words=%0d required 1 and %0d", pops - p0, xfers - x0, NW);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int p0 = pops;
    int x0 = xfers;
    m_ready = 1'b1;
    add_frames(3, 32'h0, 1'b1);
    wait_frames(exp_fc + 3, "b2b");
    checks++;
    if (pops - p0 != 3) $display("FAIL b2b_pops: got %0d required 3", pops - p0);
    else passes++;
    checks++;
    if (xfers - x0 != 3 * NW) $display("FAIL b2b_words: got %0d required %0d", xfers - x0, 3 * NW);
    else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL b2b_leftover: got %0d words required 0", sb.size());
    else passes++;
  endtask

  task automatic test_reset_mid;
    int x0 = xfers;
    int n = 0;
    m_ready = 1'b1;
    add_frames(1, 32'h0, 1'b1);
    while (xfers - x0 < 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (xfers - x0 < 6) $display("FAIL mid_timeout: got %0d words required 6", xfers - x0);
    else passes++;
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    checks++;
    if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 ||
        busy !== 1'b0 || bus.m_data !== 32'h0 || frame_cnt !== 16'h0)
      $display("FAIL mid_reset: got rd=%b v=%b l=%b b=%b d=%h fc=%h required all 0",
               bus.fifo_rd_en, bus.m_valid, bus.m_last, busy, bus.m_data, frame_cnt);
    else passes++;
    sb.delete();
    first_words.delete();
    exp_fc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    x0 = xfers;
    add_frames(1, 32'h5000, 1'b0);
    wait_frames(1, "mid_after");
    checks++;
    if (xfers - x0 != NW || frame_cnt !== 16'd1)
      $display("FAIL mid_after: got words=%0d fc=%0d required %0d and 1", xfers - x0, frame_cnt, NW);
    else passes++;
  endtask

`ifdef DATAFRAME_READER_HEADER_EN
  task automatic test_header;
    int x0;
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    first_words.delete();
    exp_fc = 0;
    @(negedge clk);
    rstb = 1'b1;
    x0 = xfers;
    m_ready = 1'b1;
    add_frames(2, 32'h0, 1'b1);
    wait_frames(2, "hdr");
    checks++;
    if (xfers - x0 != 30) $display("FAIL hdr_words: got %0d required 30", xfers - x0);
    else passes++;
    checks++;
    if (first_words.size() < 2 || first_words[0] !== 32'hDF5A0000 || first_words[1] !== 32'hDF5A0001)
      $display("FAIL hdr_values: got %0d headers required DF5A0000 then DF5A0001", first_words.size());
    else passes++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_empty();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef DATAFRAME_READER_HEADER_EN
    test_header();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dataframe_reader.md
# dataframe_reader

Drain side of the pixel-buffer frame store. Watches the store's occupancy, pops one 448-bit data frame at a time, and serializes it into 32-bit words on a valid/ready stream toward the Caribou readout path. It owns the store's read enable and respects the store memory's read latency, so a frame is never captured before the memory output has settled on the new head.

## Interface
- RD_LAT, 2, store memory read latency in clk cycles from a read-head change to valid frame data (range 1..7)
- clk  in  1  clock
- rstb  in  1  reset: asynchronous, active-low
- fifo_data  in  448  head frame from the store memory output
- fifo_num_elem  in  7  store occupancy
- fifo_rd_en  out  1  one-cycle pop strobe to the store
- m_data  out  32  stream word
- m_valid  out  1  word valid
- m_ready  in  1  downstream accept
- m_last  out  1  marks the final word of a frame
- busy  out  1  high while a frame is being streamed
- frame_cnt  out  16  frames fully streamed since reset; wraps 0xFFFF→0

## Operation
- States: IDLE, SEND.
- settle: 4-bit counter.
  - Decrements each cycle while nonzero, in every state.
  - Reset value RD_LAT.
- IDLE→SEND requires fifo_num_elem != 0 and settle == 0. At that edge:
  - The shift register loads fifo_data.
  - fifo_rd_en is set to 1.
  - m_valid is set to 1.
  - The word index is cleared.
  - settle loads RD_LAT+2.
- fifo_rd_en is registered and high for exactly one cycle per captured frame. It is never asserted in any other situation, including when the store is empty.
- SEND behaviour:
  - m_data is shift register bits [31:0].
  - Word 0 is frame bits [31:0]; word 13 is bits [447:416].
  - On m_valid && m_ready, the register shifts right 32 and the index increments.
- m_last is high while the index is 13. A transfer with m_last high does the following:
  - increments frame_cnt;
  - clears m_valid;
  - returns to IDLE.
- Stream rules:
  - While m_valid is high and m_ready is low, m_data and m_last hold stable.
  - m_valid never drops without a transfer.
- busy equals (state == SEND).
- Reset mid-frame:
  - All state clears immediately.
  - The partially sent frame is discarded. It was already popped, so it is lost.
  - frame_cnt is not incremented for it.

## Timing
- Reset values:
  - fifo_rd_en 0, m_valid 0, m_last 0, busy 0.
  - m_data 0, frame_cnt 0.
  - state IDLE, settle RD_LAT.
- Capture edge E0 → m_valid and fifo_rd_en are high after E0. The store moves its head at E1.
- settle reaches 0 at E0+RD_LAT+2, so the next frame's data has settled before the next capture.
- Minimum frame period: max(14 + 1, RD_LAT + 3) cycles with m_ready held high. The +1 is the IDLE re-capture cycle.
- The first word is available 1 cycle after the capture decision.
- Throughput is one word per cycle under continuous m_ready.
- fifo_num_elem is sampled only in IDLE with settle == 0. Its one-cycle update lag after a pop is covered by settle.

## Configuration
- DATAFRAME_READER_HEADER_EN
  - Defined: each frame is prefixed with one header word {16'hDF5A, frame_cnt[15:0]}. The counter value is the one before the increment. The frame is 15 words; m_last is on the last data word. The header is word index 0 and the data indices shift by one.
  - Undefined: 14 words per frame, no header.
- Everything else is identical in both builds.

## Structure
- Shared package dataframe_pkg holds:
  - FRAME_W = 448, WORD_W = 32, WORDS_PER_FRAME = 14;
  - HDR_MAGIC = 16'hDF5A;
  - the state enum typedef.
- The store block imports the same package for FRAME_W.
- One natural sub-module: dataframe_serializer. It holds the shift register, the word index, the m_valid/m_last handshake and the optional header insertion. The top holds the FSM, settle, the pop strobe and frame_cnt.

## Test plan
- Single frame: fifo_num_elem 1, frame word k = 0x1000+k, m_ready held 1.
  - Exactly one fifo_rd_en pulse.
  - m_data 0x1000..0x100D on consecutive cycles, m_last only on 0x100D.
  - frame_cnt ends at 1.
- Backpressure: toggle m_ready pseudo-randomly at 50%.
  - m_data and m_last are stable on every stalled cycle.
  - 14 transfers, none duplicated or dropped.
- Empty store: fifo_num_elem 0 for 100 cycles after reset.
  - fifo_rd_en and m_valid stay 0.
- Back-to-back frames: fifo_num_elem 3, RD_LAT 2, data changes RD_LAT cycles after each pop.
  - 3 pops, 42 words in order.
  - Each frame's words match its own store entry, never the stale one.
- Reset mid-frame: assert rstb low after word 5.
  - All outputs are 0 immediately.
  - After release, the next frame starts at word 0 and frame_cnt is 0.
- Header build (DATAFRAME_READER_HEADER_EN), two frames.
  - Headers are 0xDF5A0000 then 0xDF5A0001.
  - 15 words per frame, m_last on the 15th.
